// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   DEF_BIN_W  : default binary input width
//   DEF_DIGITS : default number of BCD digits
//   pow10(n)   : 10**n as a 64-bit constant, used as the overflow threshold
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_BIN_W  = 20;
  localparam int DEF_DIGITS = 6;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit.sv
// Combinational double-dabble cell: adds 3 to a BCD nibble that is >= 5 so
// that the following left shift carries correctly into the next digit.
//   i_nib : scratch digit before correction
//   o_nib : corrected digit (i_nib + 3 when i_nib >= 5, else i_nib)
module bcd_dabble_digit (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Feeds six seven-segment decoders: digit i of bcd drives HEXi.
// The last result is held between conversions so the display is steady.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : in_bin holds a value to convert
//   in_ready  : high only while idle; transfer on in_valid && in_ready
//   in_bin    : unsigned binary value
//   bcd       : packed BCD result, digit 0 in [3:0]; all 4'hF on overflow
//   out_valid : one-cycle pulse when bcd/ovf/blank update
//   ovf       : last accepted value did not fit in DIGITS decimal digits
//   blank     : leading-zero mask, bit i set when digit i is a leading zero
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_THR = pow10(DIGITS);

  state_t              r_state;
  logic [BIN_W-1:0]    r_bin_sr;
  logic [BCD_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_flag;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_ovf;
  logic                r_out_valid;
  logic [DIGITS-1:0]   r_blank;

  logic [BCD_W-1:0]    w_adj;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zero_above;

  // Add-3 correction applied to every scratch digit before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // Leading-zero mask from the finished scratch value; digit 0 is never
  // blanked so a zero result still shows a single "0".
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i]   = w_zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bin_sr    <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_ovf_flag  <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin_sr   <= in_bin;
            r_scratch  <= '0;
            r_cnt      <= CNT_W'(BIN_W);
            r_ovf_flag <= (64'(in_bin) >= OVF_THR);
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // {scratch, bin_sr} shifts as one register; the carry out of the
          // top digit is dropped (only reachable when overflow is flagged).
          r_scratch <= {w_adj[BCD_W-2:0], r_bin_sr[BIN_W-1]};
          r_bin_sr  <= {r_bin_sr[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_ovf_flag) begin
            r_bcd   <= '1;
            r_ovf   <= 1'b1;
            r_blank <= '0;
          end else begin
            r_bcd   <= r_scratch;
            r_ovf   <= 1'b0;
            r_blank <= w_blank;
          end
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign bcd       = r_bcd;
  assign ovf       = r_ovf;
  assign blank     = r_blank;
  assign out_valid = r_out_valid;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per cycle.
- Sits directly upstream of the six bcd7seg instances: its packed BCD output bus drives their 4-bit nibble inputs, HEX0 from bcd[3:0] through HEX5 from bcd[23:20].
- Holds the last result stable between conversions so the display does not flicker, and flags values that do not fit in the available digits.

Parameters:
- BIN_W, 20: width of the binary input in bits.
- DIGITS, 6: number of BCD digits produced. One digit per seven-segment display.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  in_bin holds a value to convert.
- in_ready  output  1  block can accept a value; high only in IDLE.
- in_bin  input  BIN_W  unsigned binary value to convert.
- bcd  output  4*DIGITS  packed result; digit i at [4i+3:4i], digit 0 is least significant.
- out_valid  output  1  one-cycle pulse when bcd, ovf and blank update.
- ovf  output  1  last accepted value was >= 10^DIGITS.
- blank  output  DIGITS  leading-zero mask; bit i set means digit i is a leading zero.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, bcd = 0, out_valid = 0, ovf = 0.
  - blank = all ones except bit 0 (a lone "0" is displayed).
  - Shift registers are cleared.
  - Any in-flight conversion is abandoned; no out_valid is produced for it.
  - in_valid is ignored in any cycle where rst_n is low.
- in_ready is a combinational decode: it equals (state == IDLE).
- Input handshake: a transfer happens on a rising edge where in_valid && in_ready. in_bin is captured into an internal shift register, the BCD scratch register is cleared, the bit counter is loaded with BIN_W, and state moves to SHIFT.
- SHIFT state, once per cycle:
  - Add 3 to every scratch digit that is >= 5.
  - Shift {scratch, bin_sr} left by one bit as a single register.
  - Decrement the counter. After BIN_W shifts, move to DONE.
- DONE state, one cycle:
  - bcd is loaded from scratch, or all ones (4'hF per digit, displays "FFFFFF") if the overflow flag is set.
  - ovf and blank are updated, out_valid = 1, and state returns to IDLE.
- Overflow detect: at capture, in_bin >= 10^DIGITS (a constant of at least BIN_W+1 bits) sets an internal flag. The scratch register is DIGITS*4 bits; any carry out of its top digit is discarded.
- blank[i] = 1 if digit i and every higher digit are zero, for i >= 1. blank[0] is always 0. When ovf = 1, blank = 0.
- Latency: handshake on edge 0; out_valid is high during the cycle after edge BIN_W+1 (cycle 21 with defaults). Throughput is one conversion per BIN_W+2 cycles.
- A new input can be accepted on the edge at which out_valid is high, because state is already IDLE by then. No back-pressure on the output side.
- bcd, ovf and blank hold their values between out_valid pulses and do not change during SHIFT.
- in_bin changing after acceptance has no effect on the conversion in progress.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Default constants BIN_W and DIGITS.
  - Function pow10(n) returning the overflow threshold.
- One sub-module: bcd_dabble_digit, a combinational 4-bit "if >= 5 then add 3" cell, instantiated DIGITS times with a generate loop.

Test Plan:
- Reset, then in_bin = 0 -> bcd = 24'h000000, blank = 6'b111110, ovf = 0, out_valid on cycle 21 after the handshake.
- in_bin = 123456 (20'h1E240) -> bcd = 24'h123456, blank = 0, ovf = 0. in_ready is low on cycles 1..21 and high again on the out_valid cycle.
- in_bin = 705 -> bcd = 24'h000705, blank = 6'b111000. Then 999999 -> bcd = 24'h999999, blank = 0.
- in_bin = 1000000 -> ovf = 1, bcd = 24'hFFFFFF, blank = 0. A following conversion of 42 -> ovf = 0, bcd = 24'h000042.
- in_valid held high with 11 then 22 -> first result on cycle 21, second accepted on that same edge, second out_valid 22 cycles later. bcd stays at 24'h000011 in between.
- Start converting 555555, assert rst_n low on SHIFT cycle 10 -> next cycle bcd = 0, in_ready = 1, and no out_valid is produced for 555555.
